lab1_imul_dot_seq: RTL and testbench

LAB1_IMUL_DOT_SEQ -- requirements
Module: lab1_imul_dot_seq

---
 rtl/lab1_imul_dot_seq.sv | 118 +++++++++++
 tb/tb_lab1_imul_dot_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_dot_seq.sv
// Dot-product sequencer: accepts operand pairs one at a time, sends each pair
// to an external multiplier, accumulates the returned products and presents
// the vector sum and element count once the final pair has been multiplied.
module lab1_imul_dot_seq #(
    parameter int p_nbits = 32,
    parameter int p_cbits = 8
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_nbits-1:0]     in_a,
    input  logic [p_nbits-1:0]     in_b,
    input  logic                   in_last,

    output logic                   mul_req_val,
    input  logic                   mul_req_rdy,
    output logic [2*p_nbits-1:0]   mul_req_msg,

    input  logic                   mul_resp_val,
    output logic                   mul_resp_rdy,
    input  logic [p_nbits-1:0]     mul_resp_msg,

    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_nbits-1:0]     out_sum,
    output logic [p_cbits-1:0]     out_count
);

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [p_cbits-1:0] COUNT_ONE = {{(p_cbits-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [p_nbits-1:0] a_reg;
    logic [p_nbits-1:0] b_reg;
    logic               last_reg;
    logic [p_nbits-1:0] acc;
    logic [p_cbits-1:0] count;

    logic in_fire;
    logic req_fire;
    logic resp_fire;
    logic out_fire;

    // Element counter sticks at its maximum rather than rolling over.
    function automatic logic [p_cbits-1:0] sat_inc(input logic [p_cbits-1:0] c);
        return (&c) ? c : c + COUNT_ONE;
    endfunction

    // Handshake strobes are all qualified by Moore outputs, so a stray
    // response outside WAIT never fires.
    assign in_fire   = in_val       && in_rdy;
    assign req_fire  = mul_req_val  && mul_req_rdy;
    assign resp_fire = mul_resp_val && mul_resp_rdy;
    assign out_fire  = out_val      && out_rdy;

    // Next-state decode; one multiply in flight at a time.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACCEPT: if (in_fire)   state_next = ST_ISSUE;
            ST_ISSUE:  if (req_fire)  state_next = ST_WAIT;
            ST_WAIT:   if (resp_fire) state_next = last_reg ? ST_DONE : ST_ACCEPT;
            ST_DONE:   if (out_fire)  state_next = ST_ACCEPT;
            default:                  state_next = ST_ACCEPT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCEPT;
        else     state <= state_next;
    end

    // Operand capture; held while the request waits for the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            last_reg <= 1'b0;
        end else if (in_fire) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            last_reg <= in_last;
        end
    end

    // Accumulate each product (wrapping) and count elements; cleared once
    // the result has been consumed so the next vector starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (resp_fire) begin
            acc   <= acc + mul_resp_msg;
            count <= sat_inc(count);
        end else if (out_fire) begin
            acc   <= '0;
            count <= '0;
        end
    end

    assign in_rdy       = (state == ST_ACCEPT);
    assign mul_req_val  = (state == ST_ISSUE);
    assign mul_resp_rdy = (state == ST_WAIT);
    assign out_val      = (state == ST_DONE);

    assign mul_req_msg  = {a_reg, b_reg};
    assign out_sum      = out_val ? acc   : '0;
    assign out_count    = out_val ? count : '0;

endmodule

// File: tb/tb_lab1_imul_dot_seq.sv
// Bench for lab1_imul_dot_seq: a behavioural multiplier with configurable
// latency and request stalls, a consumer with configurable hold-off, and a
// scoreboard monitor that checks every result transfer against queued values.
module tb_lab1_imul_dot_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        mul_req_val;
    logic        mul_req_rdy;
    logic [63:0] mul_req_msg;
    logic        mul_resp_val;
    logic        mul_resp_rdy;
    logic [31:0] mul_resp_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_sum;
    logic [7:0]  out_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_sum_q[$];
    logic [7:0]  exp_cnt_q[$];

    // Multiplier / consumer knobs
    int fixed_delay = 0;
    bit rand_delay  = 0;
    bit req_stall   = 0;
    bit spur_en     = 0;
    int hold_target = 0;
    int hold_cnt    = 0;

    // Multiplier model state
    logic        m_busy;
    logic        m_resp;
    logic [31:0] m_prod;
    int          m_cnt;

    lab1_imul_dot_seq #(.p_nbits(32), .p_cbits(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_last      (in_last),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_sum      (out_sum),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural multiplier sharing the DUT reset; spurious valids are
    // injected only while it is idle, i.e. while the DUT is not in WAIT.
    assign mul_resp_val = m_resp | (spur_en & ~m_busy);
    assign mul_resp_msg = m_resp ? m_prod : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_resp <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (mul_req_val && mul_req_rdy) begin
                m_busy <= 1'b1;
                m_prod <= mul_req_msg[63:32] * mul_req_msg[31:0];
                m_cnt  <= rand_delay ? int'($urandom_range(0, 34)) : fixed_delay;
            end
        end else if (!m_resp) begin
            if (m_cnt == 0) m_resp <= 1'b1;
            else            m_cnt  <= m_cnt - 1;
        end else if (mul_resp_rdy) begin
            m_resp <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    // Request-side stalls and consumer hold-off, updated just after each edge.
    always @(posedge clk) begin
        #2;
        mul_req_rdy = req_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_val) begin
            if (hold_cnt < hold_target) begin
                out_rdy = 1'b0;
                hold_cnt++;
            end else begin
                out_rdy = 1'b1;
            end
        end else begin
            out_rdy  = (hold_target == 0);
            hold_cnt = 0;
        end
    end

    // Scoreboard monitor plus protocol checks, sampled mid-cycle.
    logic        req_pend = 1'b0;
    logic [63:0] req_msg_prev;
    logic        out_pend = 1'b0;
    logic [31:0] sum_prev;
    logic [7:0]  cnt_prev;

    always @(negedge clk) begin
        if (rst) begin
            req_pend = 1'b0;
            out_pend = 1'b0;
        end else begin
            check("onehot_handshake", 64'($onehot({in_rdy, mul_req_val, mul_resp_rdy, out_val})), 64'd1);
            if (!out_val) begin
                check("idle_sum_zero", 64'(out_sum), 64'd0);
                check("idle_count_zero", 64'(out_count), 64'd0);
            end
            if (req_pend && mul_req_val)
                check("req_msg_stable", mul_req_msg, req_msg_prev);
            if (out_pend && out_val) begin
                check("out_sum_stable", 64'(out_sum), 64'(sum_prev));
                check("out_count_stable", 64'(out_count), 64'(cnt_prev));
            end
            req_pend     = mul_req_val && !mul_req_rdy;
            req_msg_prev = mul_req_msg;
            out_pend     = out_val && !out_rdy;
            sum_prev     = out_sum;
            cnt_prev     = out_count;
            if (out_val && out_rdy) begin
                if (exp_sum_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    check("out_sum", 64'(out_sum), 64'(exp_sum_q.pop_front()));
                    check("out_count", 64'(out_count), 64'(exp_cnt_q.pop_front()));
                end
            end
        end
    end

    task automatic expect_result(input logic [31:0] s, input logic [7:0] c);
        exp_sum_q.push_back(s);
        exp_cnt_q.push_back(c);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n = 0;
        @(negedge clk);
        in_a    = a;
        in_b    = b;
        in_last = last;
        in_val  = 1'b1;
        while (!in_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            check("send_timeout", 64'd1, 64'd0);
            in_val = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_val = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_sum_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_sum_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        in_val      = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_last     = 1'b0;
        mul_req_rdy = 1'b1;
        out_rdy     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_mul_req_val", 64'(mul_req_val), 64'd0);
        check("rst_mul_resp_rdy", 64'(mul_resp_rdy), 64'd0);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 2*3 + 4*5 + 6*7 = 68
        expect_result(32'd68, 8'd3);
        send(32'd2, 32'd3, 1'b0);
        send(32'd4, 32'd5, 1'b0);
        send(32'd6, 32'd7, 1'b1);
        drain();

        // single element, low word of 0xFFFFFFFF^2 is 1
        expect_result(32'h0000_0001, 8'd1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();

        // 0x10000 * 0x8000 = 0x80000000, twice -> wraps to 0
        expect_result(32'h0000_0000, 8'd2);
        send(32'h0001_0000, 32'h0000_8000, 1'b0);
        send(32'h0001_0000, 32'h0000_8000, 1'b1);
        drain();

        // random multiplier latency, request stalls, consumer hold-off
        rand_delay  = 1;
        req_stall   = 1;
        hold_target = 10;
        expect_result(32'd309, 8'd3);     // 200 + 9 + 100
        send(32'd10, 32'd20, 1'b0);
        send(32'd3, 32'd3, 1'b0);
        send(32'd100, 32'd1, 1'b1);
        expect_result(32'd14, 8'd2);      // 2 + 12
        send(32'd1, 32'd2, 1'b0);
        send(32'd3, 32'd4, 1'b1);
        drain();
        rand_delay  = 0;
        req_stall   = 0;
        hold_target = 0;
        repeat (3) @(negedge clk);

        // responses presented outside WAIT must be ignored
        spur_en = 1;
        expect_result(32'd68, 8'd3);
        send(32'd2, 32'd3, 1'b0);
        send(32'd4, 32'd5, 1'b0);
        send(32'd6, 32'd7, 1'b1);
        drain();
        spur_en = 0;

        // reset while waiting on the third of four products
        fixed_delay = 30;
        send(32'd5, 32'd5, 1'b0);
        send(32'd6, 32'd6, 1'b0);
        send(32'd7, 32'd7, 1'b0);
        n = 0;
        while (!mul_resp_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait", 64'(mul_resp_rdy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_rdy", 64'(in_rdy), 64'd1);
        check("midrst_mul_resp_rdy", 64'(mul_resp_rdy), 64'd0);
        check("midrst_out_val", 64'(out_val), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        fixed_delay = 0;
        expect_result(32'd1, 8'd1);
        send(32'd1, 32'd1, 1'b1);
        drain();

        // 300 pairs (i, 3): count saturates at 255, sum = 3*45150 = 135450
        expect_result(32'd135450, 8'd255);
        for (int i = 1; i <= 300; i++)
            send(32'(i), 32'd3, (i == 300));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
